hazard_stall_unit: RTL and testbench

- Stall/flush/halt controller for the 5-stage MIPS pipeline; companion to the forwarding path.
- Forwarding resolves hazards by bypass. This block covers the cases bypass cannot resolve by freezing PC and IF/ID and injecting ID/EX bubbles: load-use, and branch-after-load with the branch resolved in ID.
- It also handles taken-branch flush, HALT drain and debug-unit step gating.

---
 rtl/hazard_stall_unit_if.sv | 42 ++++
 rtl/hazard_stall_unit.sv | 120 ++++++++++++
 tb/tb_hazard_stall_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-control bundle between the hazard/stall unit and the datapath.
// The slave modport is the controller side; the master modport is the datapath/debug side.
interface hazard_stall_unit_if #(
  parameter int unsigned NB_REG_ADDRESS = 5,
  parameter int unsigned NB_STALL_COUNT = 16
);
  logic                      i_enable;
  logic                      i_restart;
  logic [NB_REG_ADDRESS-1:0] i_rs_if_id;
  logic [NB_REG_ADDRESS-1:0] i_rt_if_id;
  logic                      i_uses_rt_if_id;
  logic                      i_branch_if_id;
  logic                      i_branch_taken;
  logic                      i_halt_if_id;
  logic                      i_mem_read_id_ex;
  logic [NB_REG_ADDRESS-1:0] i_rt_id_ex;
  logic                      i_mem_read_ex_mem;
  logic [NB_REG_ADDRESS-1:0] i_rd_ex_mem;
  logic                      o_pc_write;
  logic                      o_if_id_write;
  logic                      o_if_id_flush;
  logic                      o_id_ex_bubble;
  logic                      o_pipe_enable;
  logic                      o_halted;
  logic [NB_STALL_COUNT-1:0] o_stall_count;

  modport slave (
    input  i_enable, i_restart, i_rs_if_id, i_rt_if_id, i_uses_rt_if_id, i_branch_if_id,
           i_branch_taken, i_halt_if_id, i_mem_read_id_ex, i_rt_id_ex, i_mem_read_ex_mem,
           i_rd_ex_mem,
    output o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble, o_pipe_enable, o_halted,
           o_stall_count
  );

  modport master (
    output i_enable, i_restart, i_rs_if_id, i_rt_if_id, i_uses_rt_if_id, i_branch_if_id,
           i_branch_taken, i_halt_if_id, i_mem_read_id_ex, i_rt_id_ex, i_mem_read_ex_mem,
           i_rd_ex_mem,
    input  o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble, o_pipe_enable, o_halted,
           o_stall_count
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/flush/halt controller for the 5-stage MIPS pipeline: load-use and branch-after-load
// stalls, taken-branch flush, HALT drain and debug step gating. Outputs are Mealy.
module hazard_stall_unit #(
  parameter int unsigned NB_REG_ADDRESS = 5,
  parameter int unsigned NB_STALL_COUNT = 16,
  parameter int unsigned DRAIN_CYCLES   = 4
) (
  input logic                i_clk,
  input logic                i_reset,
  hazard_stall_unit_if.slave bus
);

  localparam int unsigned NbDrain = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e                    state_q, state_d;
  logic [NbDrain-1:0]        drain_q, drain_d;
  logic [NB_STALL_COUNT-1:0] stall_q, stall_d;

  logic load_use, branch_load, hazard;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_enable;

  // $0 is hardwired to zero, so a load targeting it never creates a dependency.
  function automatic logic reg_match(input logic [NB_REG_ADDRESS-1:0] r,
                                     input logic [NB_REG_ADDRESS-1:0] rs,
                                     input logic [NB_REG_ADDRESS-1:0] rt,
                                     input logic                      uses_rt);
    return (r != '0) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

  always_comb begin
    load_use    = bus.i_mem_read_id_ex &&
                  reg_match(bus.i_rt_id_ex, bus.i_rs_if_id, bus.i_rt_if_id, bus.i_uses_rt_if_id);
    branch_load = bus.i_branch_if_id && bus.i_mem_read_ex_mem &&
                  reg_match(bus.i_rd_ex_mem, bus.i_rs_if_id, bus.i_rt_if_id, bus.i_uses_rt_if_id);
    hazard      = load_use || branch_load;
  end

  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    stall_d      = stall_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_enable  = 1'b1;

    // While reset is high the defaults above (plain RUN outputs) are presented.
    if (!i_reset) begin
      if (bus.i_restart || !bus.i_enable) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        pipe_enable = 1'b0;
        if (bus.i_restart) begin
          state_d = StRun;
          drain_d = '0;
          stall_d = '0;
        end
      end else begin
        unique case (state_q)
          StHalted: begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_enable = 1'b0;
          end
          StDrain: begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
            if (drain_q == '0) begin
              state_d = StHalted;
            end else begin
              drain_d = drain_q - 1'b1;
            end
          end
          StRun: begin
            // A stall hides any branch or HALT in ID; it is seen again once the stall clears.
            if (hazard) begin
              pc_write     = 1'b0;
              if_id_write  = 1'b0;
              id_ex_bubble = 1'b1;
              if (stall_q != '1) begin
                stall_d = stall_q + 1'b1;
              end
            end else if (bus.i_halt_if_id) begin
              pc_write = 1'b0;
              state_d  = StDrain;
              drain_d  = NbDrain'(DRAIN_CYCLES - 1);
            end else if (bus.i_branch_taken) begin
              if_id_flush = 1'b1;
            end
          end
          default: state_d = StRun;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StRun;
      drain_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      stall_q <= stall_d;
    end
  end

  assign bus.o_pc_write     = pc_write;
  assign bus.o_if_id_write  = if_id_write;
  assign bus.o_if_id_flush  = if_id_flush;
  assign bus.o_id_ex_bubble = id_ex_bubble;
  assign bus.o_pipe_enable  = pipe_enable;
  assign bus.o_halted       = (state_q == StHalted);
  assign bus.o_stall_count  = stall_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: inputs change on the falling edge, outputs are checked
// 1 time unit later, against hand-computed vectors {pc_write,if_id_write,flush,bubble,pipe,halted}.
module tb_hazard_stall_unit;

  localparam logic [5:0] OutRun    = 6'b110010;
  localparam logic [5:0] OutStall  = 6'b000110;
  localparam logic [5:0] OutTaken  = 6'b111010;
  localparam logic [5:0] OutHaltId = 6'b010010;
  localparam logic [5:0] OutDrain  = 6'b011010;
  localparam logic [5:0] OutFrozen = 6'b000000;
  localparam logic [5:0] OutHalted = 6'b000001;

  logic i_clk;
  logic i_reset;
  int   n_total;
  int   n_bad;

  hazard_stall_unit_if #(.NB_REG_ADDRESS(5), .NB_STALL_COUNT(16)) bus ();

  hazard_stall_unit #(
    .NB_REG_ADDRESS(5),
    .NB_STALL_COUNT(16),
    .DRAIN_CYCLES  (4)
  ) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .bus    (bus.slave)
  );

  logic [5:0] outs;
  assign outs = {bus.o_pc_write, bus.o_if_id_write, bus.o_if_id_flush, bus.o_id_ex_bubble,
                 bus.o_pipe_enable, bus.o_halted};

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_hazard_inputs();
    bus.i_restart         = 1'b0;
    bus.i_rs_if_id        = '0;
    bus.i_rt_if_id        = '0;
    bus.i_uses_rt_if_id   = 1'b0;
    bus.i_branch_if_id    = 1'b0;
    bus.i_branch_taken    = 1'b0;
    bus.i_halt_if_id      = 1'b0;
    bus.i_mem_read_id_ex  = 1'b0;
    bus.i_rt_id_ex        = '0;
    bus.i_mem_read_ex_mem = 1'b0;
    bus.i_rd_ex_mem       = '0;
  endtask

  task automatic expect_state(input string tag, input logic [5:0] o, input int cnt);
    #1;
    check_eq({tag, "_outs"}, 32'(outs), 32'(o));
    check_eq({tag, "_cnt"}, 32'(bus.o_stall_count), 32'(cnt));
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    clear_hazard_inputs();
    // Reset outputs win even over a live hazard and enable low.
    i_reset              = 1'b1;
    bus.i_enable         = 1'b0;
    bus.i_mem_read_id_ex = 1'b1;
    bus.i_rt_id_ex       = 5'd2;
    bus.i_rs_if_id       = 5'd2;
    expect_state("reset", OutRun, 0);
    repeat (2) @(posedge i_clk);

    @(negedge i_clk); i_reset = 1'b0; clear_hazard_inputs(); bus.i_enable = 1'b1;
    expect_state("idle", OutRun, 0);

    // Load-use: lw $2 in EX, add rs=2 in ID.
    @(negedge i_clk); bus.i_mem_read_id_ex = 1'b1; bus.i_rt_id_ex = 5'd2; bus.i_rs_if_id = 5'd2;
    expect_state("lu_stall", OutStall, 0);
    @(negedge i_clk); clear_hazard_inputs();
    bus.i_mem_read_ex_mem = 1'b1; bus.i_rd_ex_mem = 5'd2; bus.i_rs_if_id = 5'd2;
    expect_state("lu_after", OutRun, 1);

    // Branch after load: two stall cycles, taken ignored while stalled.
    @(negedge i_clk); clear_hazard_inputs();
    bus.i_branch_if_id = 1'b1; bus.i_branch_taken = 1'b1; bus.i_rs_if_id = 5'd3;
    bus.i_mem_read_id_ex = 1'b1; bus.i_rt_id_ex = 5'd3;
    expect_state("bl_ex", OutStall, 1);
    @(negedge i_clk); bus.i_mem_read_id_ex = 1'b0; bus.i_mem_read_ex_mem = 1'b1;
    bus.i_rd_ex_mem = 5'd3;
    expect_state("bl_mem", OutStall, 2);
    @(negedge i_clk); bus.i_mem_read_ex_mem = 1'b0;
    expect_state("bl_taken", OutTaken, 3);

    // $0 destination and rt unused never stall.
    @(negedge i_clk); clear_hazard_inputs();
    bus.i_mem_read_id_ex = 1'b1; bus.i_rt_id_ex = 5'd0; bus.i_uses_rt_if_id = 1'b1;
    expect_state("reg0", OutRun, 3);
    @(negedge i_clk); bus.i_rt_id_ex = 5'd5; bus.i_rs_if_id = 5'd1; bus.i_rt_if_id = 5'd5;
    bus.i_uses_rt_if_id = 1'b0;
    expect_state("rt_unused", OutRun, 3);

    // rt match with enable low freezes; stall resumes after enable returns.
    @(negedge i_clk); bus.i_uses_rt_if_id = 1'b1; bus.i_enable = 1'b0;
    expect_state("frz_stall", OutFrozen, 3);
    @(negedge i_clk); bus.i_enable = 1'b1;
    expect_state("rt_stall", OutStall, 3);
    @(negedge i_clk); clear_hazard_inputs();
    expect_state("rt_after", OutRun, 4);

    // HALT (with a taken branch alongside) then four drain cycles, one of them frozen.
    @(negedge i_clk); bus.i_halt_if_id = 1'b1; bus.i_branch_taken = 1'b1;
    expect_state("halt_id", OutHaltId, 4);
    @(negedge i_clk); clear_hazard_inputs();
    bus.i_mem_read_id_ex = 1'b1; bus.i_rt_id_ex = 5'd7; bus.i_rs_if_id = 5'd7;
    expect_state("drain1", OutDrain, 4);
    @(negedge i_clk); clear_hazard_inputs();
    expect_state("drain2", OutDrain, 4);
    @(negedge i_clk); bus.i_enable = 1'b0;
    expect_state("frz_drain", OutFrozen, 4);
    @(negedge i_clk); bus.i_enable = 1'b1;
    expect_state("drain3", OutDrain, 4);
    @(negedge i_clk);
    expect_state("drain4", OutDrain, 4);
    @(negedge i_clk);
    expect_state("halted", OutHalted, 4);
    @(negedge i_clk); bus.i_halt_if_id = 1'b1;
    expect_state("halted_hold", OutHalted, 4);

    // Restart pulse: frozen enables this cycle, RUN with cleared counter next.
    @(negedge i_clk); bus.i_halt_if_id = 1'b0; bus.i_restart = 1'b1;
    #1;
    check_eq("restart_outs", 32'(outs[5:1]), 32'(OutFrozen[5:1]));
    @(negedge i_clk); bus.i_restart = 1'b0;
    expect_state("restart_run", OutRun, 0);

    // Async reset in the middle of DRAIN.
    @(negedge i_clk); bus.i_mem_read_id_ex = 1'b1; bus.i_rt_id_ex = 5'd9; bus.i_rs_if_id = 5'd9;
    expect_state("pre_stall", OutStall, 0);
    @(negedge i_clk); clear_hazard_inputs(); bus.i_halt_if_id = 1'b1;
    expect_state("halt_id2", OutHaltId, 1);
    @(negedge i_clk); bus.i_halt_if_id = 1'b0;
    expect_state("drain_b", OutDrain, 1);
    #1; i_reset = 1'b1;
    expect_state("mid_reset", OutRun, 0);
    @(negedge i_clk); i_reset = 1'b0;
    expect_state("post_reset", OutRun, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
